arithmetic_execute_unit: RTL and testbench
==========================================

// Module: arithmetic_execute_unit
// PURPOSE
//  64-bit integer ALU functional unit of the Tomasulo back end. Issued ops arrive from a reservation
//  station. Computes result, condition outcome and NZCV flags, then hands them to the ROB.
//  Registered: one op accepted per cycle, result one clock after issue.
// PARAMETERS
//  none; widths fixed by data_structures.sv (GPR 64b, nzcv_t packed {N,Z,C,V} 4b)
// PORTS
//  in_clk        in   1   clock, rising edge
//  in_rst        in   1   reset, asynchronous, active-high
//  in_start      in   1   issue strobe; operands valid this cycle
//  in_alu_op     in   alu_op_t  operation select
//  in_val_a      in   64  operand A (Rn / MOVK base)
//  in_val_b      in   64  operand B (Rm or immediate)
//  in_alu_val_hw in   6   MOV insert bit position (0,16,32,48)
//  in_set_CC     in   1   1 = update flags from this op
//  in_cond       in   cond_t  ARM condition code (C_EQ..C_NV, standard 4b encoding)
//  in_prev_nzcv  in   4   current architectural flags
//  out_res       out  64  result
//  out_nzcv      out  4   flags after op
//  out_cond_val  out  1   in_cond evaluated on in_prev_nzcv
//  out_done      out  1   result valid pulse
// BEHAVIOUR
//  - Reset: out_res=0, out_nzcv=0, out_cond_val=0, out_done=0. Async assert clears immediately, including mid-op.
//  - On posedge with in_start=1: all outputs are registered from the combinational compute.
//  - out_done=1 for exactly that one following cycle, then 0.
//  - With in_start=0: out_res/out_nzcv/out_cond_val hold their last values; out_done=0.
//  - Back-to-back starts are legal; each produces a 1-cycle done.
//  - Ops (64-bit, wrap-around, no exceptions):
//      PLUS a+b; MINUS a+~b+1; AND a&b; OR a|b; EOR a^b; ORN a|~b.
//      MOV (a & ~(16'hFFFF<<hw)) | ((b[15:0])<<hw); MOVZ is issued with a=0.
//      CSEL c?a:b; CSINC c?a:b+1; CSINV c?a:~b; CSNEG c?a:-b (c = cond value).
//      PASS_A a. Any other encoding: res = 0.
//  - Condition eval on in_prev_nzcv:
//      EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V;
//      HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(GT); AL/NV 1.
//  - Flags when in_set_CC=1:
//      N = res[63]; Z = (res==0).
//      PLUS: C = carry-out bit 64; V = (a63==b63)&(res63!=a63).
//      MINUS: C = a>=b unsigned (no borrow); V = (a63!=b63)&(res63!=a63).
//      All others: C=V=0.
//  - Flags when in_set_CC=0: out_nzcv = in_prev_nzcv (pass-through).
// CONFIGURATION
//  AEU_SHIFT_OPS_EN defined: adds ALU_OP_LSL a<<b[5:0], ALU_OP_LSR logical a>>b[5:0],
//    ALU_OP_ASR arithmetic a>>>b[5:0]. Flags for these ops: N/Z from result, C=V=0.
//  Undefined: the shift encodings fall to default (res=0); done still pulses; flags per rules above.
// TESTING
//  1 PLUS a=1,b=1,set_CC=1,cond=EQ, start 1 cycle -> next cycle res=2, nzcv=0000, done=1;
//    res and nzcv held after start drops.
//  2 MINUS a=5,b=5,set_CC=1 -> res=0, nzcv=0110 (Z,C).
//    Then a=0,b=1 -> res=FFFF_FFFF_FFFF_FFFF, nzcv=1000.
//  3 PLUS a=7FFF_FFFF_FFFF_FFFF,b=1,set_CC=1 -> res=8000_0000_0000_0000, nzcv=1001.
//    Same op with set_CC=0, prev_nzcv=0110 -> nzcv=0110.
//  4 CSINC cond=EQ, prev_nzcv=0100, a=3,b=9 -> cond_val=1, res=3.
//    prev_nzcv=0000 -> cond_val=0, res=10.
//  5 MOV a=0,b=ABCD,hw=32 -> res=0000_ABCD_0000_0000.
//    AND a=F0,b=3C, set_CC=1 -> res=30, nzcv=0000.
//  6 Assert in_rst while done=1 -> outputs 0 without waiting for a clock edge.
//    With AEU_SHIFT_OPS_EN: ASR a=8000_0000_0000_0000,b=4 -> res=F800_0000_0000_0000.

Source files
------------

// File: rtl/arithmetic_execute_unit.sv
// 64-bit integer ALU functional unit: registered result, NZCV flags and condition outcome.
// Define AEU_SHIFT_OPS_EN to enable the LSL/LSR/ASR operations.
package arithmetic_execute_unit_pkg;
    typedef enum logic [4:0] {
        ALU_OP_PLUS   = 5'd0,
        ALU_OP_MINUS  = 5'd1,
        ALU_OP_AND    = 5'd2,
        ALU_OP_OR     = 5'd3,
        ALU_OP_EOR    = 5'd4,
        ALU_OP_ORN    = 5'd5,
        ALU_OP_MOV    = 5'd6,
        ALU_OP_CSEL   = 5'd7,
        ALU_OP_CSINC  = 5'd8,
        ALU_OP_CSINV  = 5'd9,
        ALU_OP_CSNEG  = 5'd10,
        ALU_OP_PASS_A = 5'd11,
        ALU_OP_LSL    = 5'd12,
        ALU_OP_LSR    = 5'd13,
        ALU_OP_ASR    = 5'd14
    } alu_op_t;

    typedef enum logic [3:0] {
        C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3,
        C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7,
        C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11,
        C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15
    } cond_t;
endpackage

module arithmetic_execute_unit
    import arithmetic_execute_unit_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_start,
    input  alu_op_t     in_alu_op,
    input  logic [63:0] in_val_a,
    input  logic [63:0] in_val_b,
    input  logic [5:0]  in_alu_val_hw,
    input  logic        in_set_CC,
    input  cond_t       in_cond,
    input  logic [3:0]  in_prev_nzcv,
    output logic [63:0] out_res,
    output logic [3:0]  out_nzcv,
    output logic        out_cond_val,
    output logic        out_done
);

    logic [63:0] r_res;
    logic [3:0]  r_nzcv;
    logic        r_cond_val;
    logic        r_done;

    logic        w_n, w_z, w_c_prev, w_v_prev;
    logic        w_cond_val;
    logic [64:0] w_sum;
    logic [64:0] w_diff;
    logic [63:0] w_mov_mask;
    logic [63:0] w_mov_ins;
    logic [63:0] w_res;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_nzcv;
`ifdef AEU_SHIFT_OPS_EN
    logic [5:0]  w_shamt;

    assign w_shamt = in_val_b[5:0];
`endif

    assign {w_n, w_z, w_c_prev, w_v_prev} = in_prev_nzcv;

    // Bit 64 of the subtract path is the no-borrow flag, i.e. a >= b unsigned.
    assign w_sum      = {1'b0, in_val_a} + {1'b0, in_val_b};
    assign w_diff     = {1'b0, in_val_a} + {1'b0, ~in_val_b} + 65'd1;
    assign w_mov_mask = 64'hFFFF << in_alu_val_hw;
    assign w_mov_ins  = {48'd0, in_val_b[15:0]} << in_alu_val_hw;

    always_comb begin
        w_cond_val = 1'b0;
        case (in_cond)
            C_EQ:       w_cond_val = w_z;
            C_NE:       w_cond_val = !w_z;
            C_CS:       w_cond_val = w_c_prev;
            C_CC:       w_cond_val = !w_c_prev;
            C_MI:       w_cond_val = w_n;
            C_PL:       w_cond_val = !w_n;
            C_VS:       w_cond_val = w_v_prev;
            C_VC:       w_cond_val = !w_v_prev;
            C_HI:       w_cond_val = w_c_prev & !w_z;
            C_LS:       w_cond_val = !(w_c_prev & !w_z);
            C_GE:       w_cond_val = (w_n == w_v_prev);
            C_LT:       w_cond_val = (w_n != w_v_prev);
            C_GT:       w_cond_val = !w_z & (w_n == w_v_prev);
            C_LE:       w_cond_val = !(!w_z & (w_n == w_v_prev));
            C_AL, C_NV: w_cond_val = 1'b1;
            default:    w_cond_val = 1'b0;
        endcase
    end

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (in_alu_op)
            ALU_OP_PLUS: begin
                w_res = w_sum[63:0];
                w_c   = w_sum[64];
                w_v   = (in_val_a[63] == in_val_b[63]) & (w_sum[63] != in_val_a[63]);
            end
            ALU_OP_MINUS: begin
                w_res = w_diff[63:0];
                w_c   = w_diff[64];
                w_v   = (in_val_a[63] != in_val_b[63]) & (w_diff[63] != in_val_a[63]);
            end
            ALU_OP_AND:    w_res = in_val_a & in_val_b;
            ALU_OP_OR:     w_res = in_val_a | in_val_b;
            ALU_OP_EOR:    w_res = in_val_a ^ in_val_b;
            ALU_OP_ORN:    w_res = in_val_a | ~in_val_b;
            ALU_OP_MOV:    w_res = (in_val_a & ~w_mov_mask) | w_mov_ins;
            ALU_OP_CSEL:   w_res = w_cond_val ? in_val_a : in_val_b;
            ALU_OP_CSINC:  w_res = w_cond_val ? in_val_a : in_val_b + 64'd1;
            ALU_OP_CSINV:  w_res = w_cond_val ? in_val_a : ~in_val_b;
            ALU_OP_CSNEG:  w_res = w_cond_val ? in_val_a : ~in_val_b + 64'd1;
            ALU_OP_PASS_A: w_res = in_val_a;
`ifdef AEU_SHIFT_OPS_EN
            ALU_OP_LSL:    w_res = in_val_a << w_shamt;
            ALU_OP_LSR:    w_res = in_val_a >> w_shamt;
            ALU_OP_ASR:    w_res = 64'($signed(in_val_a) >>> w_shamt);
`endif
            default:       w_res = '0;
        endcase
    end

    assign w_nzcv = in_set_CC ? {w_res[63], (w_res == '0), w_c, w_v} : in_prev_nzcv;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_res      <= '0;
            r_nzcv     <= '0;
            r_cond_val <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= in_start;
            if (in_start) begin
                r_res      <= w_res;
                r_nzcv     <= w_nzcv;
                r_cond_val <= w_cond_val;
            end
        end
    end

    assign out_res      = r_res;
    assign out_nzcv     = r_nzcv;
    assign out_cond_val = r_cond_val;
    assign out_done     = r_done;

endmodule

// File: tb/tb_arithmetic_execute_unit.sv
// Self-checking bench for arithmetic_execute_unit: directed cases plus randomized ops vs. a reference model.
module tb_arithmetic_execute_unit;
    import arithmetic_execute_unit_pkg::*;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_start;
    alu_op_t     in_alu_op;
    logic [63:0] in_val_a;
    logic [63:0] in_val_b;
    logic [5:0]  in_alu_val_hw;
    logic        in_set_CC;
    cond_t       in_cond;
    logic [3:0]  in_prev_nzcv;
    logic [63:0] out_res;
    logic [3:0]  out_nzcv;
    logic        out_cond_val;
    logic        out_done;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    arithmetic_execute_unit dut (
        .in_clk        (in_clk),
        .in_rst        (in_rst),
        .in_start      (in_start),
        .in_alu_op     (in_alu_op),
        .in_val_a      (in_val_a),
        .in_val_b      (in_val_b),
        .in_alu_val_hw (in_alu_val_hw),
        .in_set_CC     (in_set_CC),
        .in_cond       (in_cond),
        .in_prev_nzcv  (in_prev_nzcv),
        .out_res       (out_res),
        .out_nzcv      (out_nzcv),
        .out_cond_val  (out_cond_val),
        .out_done      (out_done)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  nzcv;
        logic        cv;
    } exp_t;

    function automatic exp_t model(input int unsigned op, input logic [63:0] a, input logic [63:0] b,
                                   input logic [5:0] hw, input logic scc, input int unsigned cond,
                                   input logic [3:0] prev);
        exp_t e;
        logic n, z, c, v, cv, fc, fv;
        logic [63:0] r;
        int unsigned sh;
        n = prev[3]; z = prev[2]; c = prev[1]; v = prev[0];
        case (cond)
            0: cv = z;            1: cv = !z;
            2: cv = c;            3: cv = !c;
            4: cv = n;            5: cv = !n;
            6: cv = v;            7: cv = !v;
            8: cv = c && !z;      9: cv = !(c && !z);
            10: cv = (n == v);    11: cv = (n != v);
            12: cv = !z && (n == v);
            13: cv = !(!z && (n == v));
            default: cv = 1'b1;
        endcase
        r = 64'd0; fc = 1'b0; fv = 1'b0;
        sh = int'(b[5:0]);
        case (op)
            0: begin
                r  = a + b;
                fc = (r < a);
                fv = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(r) < 0) ||
                     ($signed(a) < 0 && $signed(b) < 0 && $signed(r) >= 0);
            end
            1: begin
                r  = a - b;
                fc = (a >= b);
                fv = (($signed(a) < 0) != ($signed(b) < 0)) && (($signed(r) < 0) != ($signed(a) < 0));
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a | ~b;
            6: begin
                r = a;
                for (int unsigned i = 0; i < 16; i++)
                    if (int'(hw) + i < 64) r[int'(hw) + i] = b[i];
            end
            7:  r = cv ? a : b;
            8:  r = cv ? a : b + 64'd1;
            9:  r = cv ? a : ~b;
            10: r = cv ? a : 64'd0 - b;
            11: r = a;
`ifdef AEU_SHIFT_OPS_EN
            12: r = a << sh;
            13: r = a >> sh;
            14: begin
                r = a >> sh;
                if (a[63]) for (int unsigned i = 0; i < sh; i++) r[63 - i] = 1'b1;
            end
`endif
            default: r = 64'd0;
        endcase
        e.res  = r;
        e.cv   = cv;
        e.nzcv = scc ? {r[63], (r == 64'd0), fc, fv} : prev;
        return e;
    endfunction

    task automatic drive(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] hw, input logic scc, input cond_t cond, input logic [3:0] prev);
        in_alu_op = op; in_val_a = a; in_val_b = b; in_alu_val_hw = hw;
        in_set_CC = scc; in_cond = cond; in_prev_nzcv = prev;
    endtask

    // Issue for exactly one edge; returns #1 after that edge with start low.
    task automatic issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] hw, input logic scc, input cond_t cond, input logic [3:0] prev);
        drive(op, a, b, hw, scc, cond, prev);
        in_start = 1'b1;
        @(posedge in_clk);
        #1;
        in_start = 1'b0;
    endtask

    task automatic test_reset();
        in_rst = 1'b1; in_start = 1'b0;
        drive(ALU_OP_PLUS, 64'd0, 64'd0, 6'd0, 1'b0, C_EQ, 4'd0);
        #2;
        n_total++;
        if ({out_res, out_nzcv, out_cond_val, out_done} !== 70'd0)
            $display("FAIL reset_state: got res=%h nzcv=%b cv=%b done=%b, want all 0",
                     out_res, out_nzcv, out_cond_val, out_done);
        else n_pass++;
        @(negedge in_clk);
        in_rst = 1'b0;
        @(posedge in_clk); #1;
        n_total++;
        if (out_done !== 1'b0) $display("FAIL idle_done: got %b want 0", out_done);
        else n_pass++;
    endtask

    task automatic test_plus_hold();
        issue(ALU_OP_PLUS, 64'd1, 64'd1, 6'd0, 1'b1, C_EQ, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv, out_done} !== {64'd2, 4'b0000, 1'b1})
            $display("FAIL plus_1_1: got res=%h nzcv=%b done=%b want res=2 nzcv=0000 done=1",
                     out_res, out_nzcv, out_done);
        else n_pass++;
        in_prev_nzcv = 4'b1111; in_val_a = 64'hDEAD;
        repeat (3) @(posedge in_clk);
        #1;
        n_total++;
        if ({out_res, out_nzcv, out_done} !== {64'd2, 4'b0000, 1'b0})
            $display("FAIL plus_hold: got res=%h nzcv=%b done=%b want res=2 nzcv=0000 done=0",
                     out_res, out_nzcv, out_done);
        else n_pass++;
    endtask

    task automatic test_minus();
        issue(ALU_OP_MINUS, 64'd5, 64'd5, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv} !== {64'd0, 4'b0110})
            $display("FAIL minus_5_5: got res=%h nzcv=%b want 0 / 0110", out_res, out_nzcv);
        else n_pass++;
        issue(ALU_OP_MINUS, 64'd0, 64'd1, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'b1000})
            $display("FAIL minus_0_1: got res=%h nzcv=%b want ffffffffffffffff / 1000", out_res, out_nzcv);
        else n_pass++;
    endtask

    task automatic test_overflow();
        issue(ALU_OP_PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv} !== {64'h8000_0000_0000_0000, 4'b1001})
            $display("FAIL plus_ovf: got res=%h nzcv=%b want 8000000000000000 / 1001", out_res, out_nzcv);
        else n_pass++;
        issue(ALU_OP_PLUS, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b0, C_AL, 4'b0110);
        n_total++;
        if (out_nzcv !== 4'b0110) $display("FAIL nzcv_passthru: got %b want 0110", out_nzcv);
        else n_pass++;
        issue(ALU_OP_PLUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv} !== {64'd0, 4'b0110})
            $display("FAIL plus_carry: got res=%h nzcv=%b want 0 / 0110", out_res, out_nzcv);
        else n_pass++;
    endtask

    task automatic test_csinc();
        issue(ALU_OP_CSINC, 64'd3, 64'd9, 6'd0, 1'b0, C_EQ, 4'b0100);
        n_total++;
        if ({out_cond_val, out_res} !== {1'b1, 64'd3})
            $display("FAIL csinc_true: got cv=%b res=%h want 1 / 3", out_cond_val, out_res);
        else n_pass++;
        issue(ALU_OP_CSINC, 64'd3, 64'd9, 6'd0, 1'b0, C_EQ, 4'b0000);
        n_total++;
        if ({out_cond_val, out_res} !== {1'b0, 64'd10})
            $display("FAIL csinc_false: got cv=%b res=%h want 0 / a", out_cond_val, out_res);
        else n_pass++;
    endtask

    task automatic test_mov_and();
        issue(ALU_OP_MOV, 64'd0, 64'hABCD, 6'd32, 1'b0, C_AL, 4'b0000);
        n_total++;
        if (out_res !== 64'h0000_ABCD_0000_0000)
            $display("FAIL movz_hw32: got %h want 0000abcd00000000", out_res);
        else n_pass++;
        issue(ALU_OP_MOV, 64'h1111_2222_3333_4444, 64'hFFFF_0000_0000_BEEF, 6'd48, 1'b0, C_AL, 4'b0000);
        n_total++;
        if (out_res !== 64'hBEEF_2222_3333_4444)
            $display("FAIL movk_hw48: got %h want beef222233334444", out_res);
        else n_pass++;
        issue(ALU_OP_AND, 64'hF0, 64'h3C, 6'd0, 1'b1, C_AL, 4'b1111);
        n_total++;
        if ({out_res, out_nzcv} !== {64'h30, 4'b0000})
            $display("FAIL and_f0_3c: got res=%h nzcv=%b want 30 / 0000", out_res, out_nzcv);
        else n_pass++;
        issue(alu_op_t'(5'd31), 64'h55, 64'h66, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_nzcv, out_done} !== {64'd0, 4'b0100, 1'b1})
            $display("FAIL bad_op: got res=%h nzcv=%b done=%b want 0 / 0100 / 1", out_res, out_nzcv, out_done);
        else n_pass++;
    endtask

    task automatic test_shift();
        issue(ALU_OP_ASR, 64'h8000_0000_0000_0000, 64'd4, 6'd0, 1'b1, C_AL, 4'b0000);
`ifdef AEU_SHIFT_OPS_EN
        n_total++;
        if ({out_res, out_nzcv} !== {64'hF800_0000_0000_0000, 4'b1000})
            $display("FAIL asr: got res=%h nzcv=%b want f800000000000000 / 1000", out_res, out_nzcv);
        else n_pass++;
`else
        n_total++;
        if ({out_res, out_nzcv, out_done} !== {64'd0, 4'b0100, 1'b1})
            $display("FAIL asr_disabled: got res=%h nzcv=%b done=%b want 0 / 0100 / 1",
                     out_res, out_nzcv, out_done);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        issue(ALU_OP_PASS_A, 64'h1234, 64'd0, 6'd0, 1'b1, C_AL, 4'b0000);
        n_total++;
        if ({out_res, out_done} !== {64'h1234, 1'b1})
            $display("FAIL pre_reset: got res=%h done=%b want 1234 / 1", out_res, out_done);
        else n_pass++;
        #2 in_rst = 1'b1;
        #1;
        n_total++;
        if ({out_res, out_nzcv, out_cond_val, out_done} !== 70'd0)
            $display("FAIL async_reset: got res=%h nzcv=%b cv=%b done=%b want all 0",
                     out_res, out_nzcv, out_cond_val, out_done);
        else n_pass++;
        @(negedge in_clk);
        in_rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        in_start = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            drive(ALU_OP_PLUS, 64'(k * 100), 64'd7, 6'd0, 1'b1, C_AL, 4'b0000);
            e = model(0, 64'(k * 100), 64'd7, 6'd0, 1'b1, 14, 4'b0000);
            @(posedge in_clk); #1;
            n_total++;
            if ({out_res, out_nzcv, out_done} !== {e.res, e.nzcv, 1'b1})
                $display("FAIL b2b_%0d: got res=%h nzcv=%b done=%b want res=%h nzcv=%b done=1",
                         k, out_res, out_nzcv, out_done, e.res, e.nzcv);
            else n_pass++;
        end
        in_start = 1'b0;
        @(posedge in_clk); #1;
        n_total++;
        if (out_done !== 1'b0) $display("FAIL b2b_end_done: got %b want 0", out_done);
        else n_pass++;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic test_random();
        exp_t e, held;
        logic exp_done;
        int unsigned op, cond;
        logic [63:0] a, b;
        logic [5:0] hw;
        logic scc, st;
        logic [3:0] prev;
        held = '0;
        for (int unsigned it = 0; it < 400; it++) begin
            op   = $urandom_range(0, 31);
            cond = $urandom_range(0, 15);
            a    = rnd64();
            b    = ($urandom_range(0, 3) == 0) ? a : rnd64();
            hw   = 6'($urandom_range(0, 3) * 16);
            scc  = 1'($urandom_range(0, 1));
            prev = 4'($urandom_range(0, 15));
            st   = ($urandom_range(0, 9) < 7);
            drive(alu_op_t'(op[4:0]), a, b, hw, scc, cond_t'(cond[3:0]), prev);
            in_start = st;
            if (st) held = model(op, a, b, hw, scc, cond, prev);
            exp_done = st;
            @(posedge in_clk); #1;
            e = held;
            n_total++;
            if ({out_res, out_nzcv, out_cond_val, out_done} !== {e.res, e.nzcv, e.cv, exp_done})
                $display("FAIL rand_%0d op=%0d cond=%0d: got res=%h nzcv=%b cv=%b done=%b want res=%h nzcv=%b cv=%b done=%b",
                         it, op, cond, out_res, out_nzcv, out_cond_val, out_done,
                         e.res, e.nzcv, e.cv, exp_done);
            else n_pass++;
        end
        in_start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_plus_hold();
        test_minus();
        test_overflow();
        test_csinc();
        test_mov_and();
        test_shift();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
